// File: rtl/mdu_unit.sv
// Multiply/divide unit owning HI/LO for the E stage; optional MADD/MADDU when MDU_MADD_EN is defined.
// Latency: result latched at start, committed after MULT_CYCLES / DIV_CYCLES edges; Out is combinational.
// Backpressure: Busy = accepted Start or count != 0; Start during RUN and all Start/MT writes under Req are dropped.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] Out
);
    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
`endif

    logic [31:0]   hi, lo, rh, rl;
    logic          dz;
    logic [CW-1:0] count;

    logic        is_mul, is_div, start_ok;
    logic signed [63:0] sa64, sb64;
    logic signed [31:0] sa32, sb32;
    logic [63:0] prod_s, prod_u, res;
    logic [31:0] b_safe, q_s, r_s, q_u, r_u;

    always_comb begin
        is_mul = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mul = is_mul || (MDUOp == OP_MADD) || (MDUOp == OP_MADDU);
`endif
        is_div   = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
        start_ok = Start && (is_mul || is_div) && !Req && (count == '0);
        Busy     = (Start && (is_mul || is_div) && !Req) || (count != '0);
    end

    always_comb begin
        sa64   = {{32{A[31]}}, A};
        sb64   = {{32{B[31]}}, B};
        prod_s = sa64 * sb64;
        prod_u = {32'd0, A} * {32'd0, B};
        // Divisor forced nonzero so the dividers never produce X; the dz flag blocks commit.
        b_safe = (B == 32'd0) ? 32'd1 : B;
        sa32   = A;
        sb32   = b_safe;
        if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
            q_s = 32'h8000_0000;
            r_s = 32'd0;
        end else begin
            q_s = sa32 / sb32;
            r_s = sa32 % sb32;
        end
        q_u = A / b_safe;
        r_u = A % b_safe;
        case (MDUOp)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV:   res = {r_s, q_s};
            OP_DIVU:  res = {r_u, q_u};
`ifdef MDU_MADD_EN
            OP_MADD:  res = {hi, lo} + prod_s;
            OP_MADDU: res = {hi, lo} + prod_u;
`endif
            default:  res = 64'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi    <= 32'd0;
            lo    <= 32'd0;
            rh    <= 32'd0;
            rl    <= 32'd0;
            dz    <= 1'b0;
            count <= '0;
        end else if (count != '0) begin
            // An in-flight op belongs to an older instruction, so Req does not stop it.
            if (count == CW'(1)) begin
                if (!dz) begin
                    hi <= rh;
                    lo <= rl;
                end
                count <= '0;
            end else begin
                count <= count - CW'(1);
            end
        end else if (!Req) begin
            if (start_ok) begin
                rh    <= res[63:32];
                rl    <= res[31:0];
                dz    <= is_div && (B == 32'd0);
                count <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end else if (MDUOp == OP_MTHI) begin
                hi <= A;
            end else if (MDUOp == OP_MTLO) begin
                lo <= A;
            end
        end
    end

    always_comb begin
        case (MDUOp)
            OP_MFHI: Out = hi;
            OP_MFLO: Out = lo;
            default: Out = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: directed vector table, hand-written corner sequences, random ops against a 64-bit arithmetic model.
module tb_mdu_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  MDUOp = 4'd0;
    logic        Start = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        Req = 1'b0;
    logic        Busy;
    logic [31:0] Out;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset_n(reset_n), .MDUOp(MDUOp), .Start(Start),
        .A(A), .B(B), .Req(Req), .Busy(Busy), .Out(Out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural HI/LO pair.
    task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        longint unsigned ua, ub, pu;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            4'd1: begin p = sa * sb; {m_hi, m_lo} = p; end
            4'd2: begin pu = ua * ub; {m_hi, m_lo} = pu; end
            4'd3: if (b != 0) begin p = sa / sb; m_lo = p[31:0]; p = sa % sb; m_hi = p[31:0]; end
            4'd4: if (b != 0) begin pu = ua / ub; m_lo = pu[31:0]; pu = ua % ub; m_hi = pu[31:0]; end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
`ifdef MDU_MADD_EN
            4'd9:  begin p = sa * sb; {m_hi, m_lo} = {m_hi, m_lo} + p; end
            4'd10: begin pu = ua * ub; {m_hi, m_lo} = {m_hi, m_lo} + pu; end
`endif
            default: ;
        endcase
    endtask

    // Called just after a falling edge; stays within the low phase.
    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        MDUOp = 4'd7; #1 h = Out;
        MDUOp = 4'd8; #1 l = Out;
        MDUOp = 4'd0; #1;
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] a, input logic req);
        @(negedge clk); MDUOp = op; A = a; Req = req;
        @(negedge clk); MDUOp = 4'd0; A = 32'd0; Req = 1'b0;
        if (!req) model_apply(op, a, 32'd0);
        #1;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit mid_req, input bit intrude, output int bc);
        int guard;
        @(negedge clk); MDUOp = op; Start = 1'b1; A = a; B = b;
        #1 bc = Busy ? 1 : 0;
        @(negedge clk); Start = 1'b0; MDUOp = 4'd0; A = 32'd0; B = 32'd0;
        if (mid_req) Req = 1'b1;
        if (intrude) begin Start = 1'b1; MDUOp = 4'd1; A = 32'h55; B = 32'h55; end
        #1 guard = 0;
        while (Busy && guard < 100) begin
            bc++; guard++;
            @(negedge clk); Req = 1'b0; Start = 1'b0; MDUOp = 4'd0; A = 32'd0; B = 32'd0;
            #1;
        end
        if (guard >= 100) begin
            errors++; checks++;
            $display("FAIL busy_timeout: Busy still 1 after %0d cycles, expected release", guard);
        end
    endtask

    vec_t vecs[8];
    logic [31:0] h, l;
    int bc;

    initial begin
        vecs[0] = '{4'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 6};
        vecs[1] = '{4'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 11};
        vecs[2] = '{4'd4, 32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 32'h7FFF_FFFC, 11};
        vecs[3] = '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 6};
        vecs[4] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 11};
        vecs[5] = '{4'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 6};
        vecs[6] = '{4'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 11};
        vecs[7] = '{4'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 6};

        // Reset state
        #1 chk("reset_busy", {31'd0, Busy}, 32'd0);
        read_hilo(h, l);
        chk("reset_hi", h, 32'd0);
        chk("reset_lo", l, 32'd0);
        chk("reset_out_nop", Out, 32'd0);
        @(negedge clk); reset_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0, bc);
            chk($sformatf("vec%0d_busy", i), 32'(bc), 32'(vecs[i].busy));
            read_hilo(h, l);
            chk($sformatf("vec%0d_hi", i), h, vecs[i].hi);
            chk($sformatf("vec%0d_lo", i), l, vecs[i].lo);
            m_hi = vecs[i].hi; m_lo = vecs[i].lo;
        end

        // Divide by zero keeps HI/LO
        mt(4'd5, 32'h1234, 1'b0);
        mt(4'd6, 32'h5678, 1'b0);
        run_op(4'd3, 32'd9, 32'd0, 1'b0, 1'b0, bc);
        chk("div0_busy", 32'(bc), 32'd11);
        read_hilo(h, l);
        chk("div0_hi", h, 32'h1234);
        chk("div0_lo", l, 32'h5678);

        // Req blocks MT and Start; a running op still commits through a Req pulse
        mt(4'd6, 32'hAA, 1'b1);
        chk("req_mt_busy", {31'd0, Busy}, 32'd0);
        read_hilo(h, l);
        chk("req_mt_lo", l, 32'h5678);
        @(negedge clk); MDUOp = 4'd1; Start = 1'b1; A = 32'd2; B = 32'd2; Req = 1'b1;
        @(negedge clk); MDUOp = 4'd0; Start = 1'b0; Req = 1'b0;
        #1 chk("req_start_busy", {31'd0, Busy}, 32'd0);
        read_hilo(h, l);
        chk("req_start_hi", h, 32'h1234);
        chk("req_start_lo", l, 32'h5678);
        run_op(4'd2, 32'd2, 32'd2, 1'b1, 1'b0, bc);
        model_apply(4'd2, 32'd2, 32'd2);
        chk("req_mid_busy", 32'(bc), 32'd6);
        read_hilo(h, l);
        chk("req_mid_hi", h, 32'd0);
        chk("req_mid_lo", l, 32'd4);

        // Start while busy is ignored
        run_op(4'd4, 32'd100, 32'd7, 1'b0, 1'b1, bc);
        model_apply(4'd4, 32'd100, 32'd7);
        chk("intrude_busy", 32'(bc), 32'd11);
        read_hilo(h, l);
        chk("intrude_hi", h, 32'd2);
        chk("intrude_lo", l, 32'd14);

        // MFLO in the commit cycle sees the old value, new value next cycle
        @(negedge clk); MDUOp = 4'd2; Start = 1'b1; A = 32'd5; B = 32'd5;
        @(negedge clk); MDUOp = 4'd0; Start = 1'b0;
        repeat (4) @(negedge clk);
        MDUOp = 4'd8;
        #1 chk("commit_cycle_busy", {31'd0, Busy}, 32'd1);
        chk("commit_cycle_old_lo", Out, 32'd14);
        @(negedge clk); #1;
        chk("after_commit_busy", {31'd0, Busy}, 32'd0);
        chk("after_commit_lo", Out, 32'd25);
        MDUOp = 4'd0;
        model_apply(4'd2, 32'd5, 32'd5);

        // Optional MADD ops
`ifdef MDU_MADD_EN
        mt(4'd5, 32'd0, 1'b0);
        mt(4'd6, 32'hFFFF_FFFF, 1'b0);
        run_op(4'd10, 32'd1, 32'd1, 1'b0, 1'b0, bc);
        model_apply(4'd10, 32'd1, 32'd1);
        chk("maddu_busy", 32'(bc), 32'd6);
        read_hilo(h, l);
        chk("maddu_hi", h, 32'd1);
        chk("maddu_lo", l, 32'd0);
`else
        @(negedge clk); MDUOp = 4'd9; Start = 1'b1; A = 32'd3; B = 32'd3;
        #1 chk("op9_busy_now", {31'd0, Busy}, 32'd0);
        @(negedge clk); MDUOp = 4'd0; Start = 1'b0;
        #1 chk("op9_busy_after", {31'd0, Busy}, 32'd0);
        read_hilo(h, l);
        chk("op9_hi", h, m_hi);
        chk("op9_lo", l, m_lo);
`endif

        // Random ops against the model
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [31:0] ra, rb;
            op = 4'($urandom_range(1, 6));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
            if (op >= 4'd5) begin
                mt(op, ra, 1'b0);
            end else begin
                run_op(op, ra, rb, 1'b0, 1'b0, bc);
                model_apply(op, ra, rb);
                chk($sformatf("rnd%0d_op%0d_busy", i, op), 32'(bc), (op >= 4'd3) ? 32'd11 : 32'd6);
            end
            read_hilo(h, l);
            chk($sformatf("rnd%0d_op%0d_hi", i, op), h, m_hi);
            chk($sformatf("rnd%0d_op%0d_lo", i, op), l, m_lo);
        end

        // Reset mid-operation aborts and clears
        mt(4'd5, 32'hDEAD, 1'b0);
        mt(4'd6, 32'hBEEF, 1'b0);
        @(negedge clk); MDUOp = 4'd1; Start = 1'b1; A = 32'd3; B = 32'd7;
        @(negedge clk); MDUOp = 4'd0; Start = 1'b0;
        @(negedge clk); reset_n = 1'b0;
        #1 chk("rst_mid_busy", {31'd0, Busy}, 32'd0);
        read_hilo(h, l);
        chk("rst_mid_hi", h, 32'd0);
        chk("rst_mid_lo", l, 32'd0);
        @(negedge clk); reset_n = 1'b1;
        repeat (8) @(negedge clk);
        #1 chk("rst_after_busy", {31'd0, Busy}, 32'd0);
        read_hilo(h, l);
        chk("rst_after_hi", h, 32'd0);
        chk("rst_after_lo", l, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
